add_mol_rr_scheduler: RTL and testbench

//  Shares one fixed-latency __main__add_mol pipeline among NUM_REQ requesters.
//  - Round-robin issues at most one operand per cycle into the pipeline.
//  - Tracks each in-flight op's requester tag alongside the datapath.
//  - Returns each result to its requester when the result emerges.
//  The add_mol pipeline has no valid, stall or reset; this block owns all of that.

---
 rtl/add_mol_rr_scheduler_if.sv | 31 +++
 rtl/add_mol_rr_scheduler.sv | 96 +++++++++
 tb/tb_add_mol_rr_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/add_mol_rr_scheduler_if.sv
// Interface bundling requester, add_mol pipeline and response signals for add_mol_rr_scheduler.
`default_nettype none

interface add_mol_rr_scheduler_if #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int PIPE_LAT = 2
);
  logic                           enable;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*DATA_W-1:0]      req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [DATA_W-1:0]              pipe_x;
  logic [DATA_W-1:0]              pipe_out;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;
  logic [$clog2(PIPE_LAT+1)-1:0]  in_flight;
  logic                           idle;

  modport master (
    output enable, req_valid, req_data, pipe_out,
    input  req_ready, pipe_x, rsp_valid, rsp_data, in_flight, idle
  );

  modport slave (
    input  enable, req_valid, req_data, pipe_out,
    output req_ready, pipe_x, rsp_valid, rsp_data, in_flight, idle
  );
endinterface

`default_nettype wire

// File: rtl/add_mol_rr_scheduler.sv
// Round-robin sharing of one fixed-latency add_mol pipeline among NUM_REQ requesters,
// with a tag shift register that routes each result back to its issuer.
`default_nettype none

module add_mol_rr_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int PIPE_LAT = 2
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  add_mol_rr_scheduler_if.slave s
);
  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(PIPE_LAT + 1);

  logic [TAG_W-1:0]    r_rr_ptr;
  logic [TAG_W-1:0]    w_winner;
  logic                w_found;
  logic                w_issue;
  logic [PIPE_LAT-1:0] r_v;
  logic [TAG_W-1:0]    r_tag [PIPE_LAT];
  logic [PIPE_LAT-1:0] w_v_nxt;
  logic [CNT_W-1:0]    r_in_flight;
  logic [CNT_W-1:0]    w_in_flight_nxt;

  // Rotating priority scan starting at r_rr_ptr; gating with rst_n keeps grants off during reset.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && s.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_found  = 1'b1;
        w_winner = TAG_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
    w_issue = w_found & s.enable & rst_n;
  end

  always_comb begin
    s.req_ready = '0;
    s.pipe_x    = '0;
    if (w_issue) begin
      s.req_ready[w_winner] = 1'b1;
      s.pipe_x              = s.req_data[w_winner*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_v_nxt[0]      = w_issue;
    for (int i = 1; i < PIPE_LAT; i++) begin
      w_v_nxt[i] = r_v[i-1];
    end
    w_in_flight_nxt = '0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      w_in_flight_nxt = w_in_flight_nxt + CNT_W'(w_v_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_v         <= '0;
      r_in_flight <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_v         <= w_v_nxt;
      r_in_flight <= w_in_flight_nxt;
      r_tag[0]    <= w_winner;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
      if (w_issue) begin
        r_rr_ptr <= (w_winner == TAG_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
      end
    end
  end

  // Only the valid bit qualifies pipe_out, so add_mol's unreset contents never leak out.
  always_comb begin
    s.rsp_valid = '0;
    s.rsp_data  = '0;
    if (r_v[PIPE_LAT-1]) begin
      s.rsp_valid[r_tag[PIPE_LAT-1]] = 1'b1;
      s.rsp_data                     = s.pipe_out;
    end
  end

  assign s.in_flight = r_in_flight;
  assign s.idle      = (r_in_flight == '0) && !w_issue;

endmodule

`default_nettype wire

// File: tb/tb_add_mol_rr_scheduler.sv
// Scoreboard bench for add_mol_rr_scheduler with a behavioural two-stage add_mol model.
`default_nettype none

module tb_add_mol_rr_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc_n = 0;
  int   checks = 0;
  int   failures = 0;
  logic rand_mode = 1'b0;
  logic [31:0] rand_val = '0;
  logic [31:0] m_s1 = '0;
  logic [31:0] m_s2 = '0;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  add_mol_rr_scheduler_if #(.NUM_REQ(4), .DATA_W(32), .PIPE_LAT(2)) ifc ();

  add_mol_rr_scheduler #(.NUM_REQ(4), .DATA_W(32), .PIPE_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (ifc.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_n    <= cyc_n + 1;
    m_s1     <= {ifc.pipe_x[31:1] + 31'd21, ifc.pipe_x[0]};
    m_s2     <= m_s1;
    rand_val <= $urandom;
  end

  assign ifc.pipe_out = rand_mode ? rand_val : m_s2;

  function automatic logic [31:0] addmol(input logic [31:0] x);
    return {x[31:1] + 31'd21, x[0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic cyc(input logic en, input logic [3:0] v, input logic [127:0] d,
                     input logic [3:0] exp_rdy, input int exp_if, input logic exp_idle,
                     input logic [31:0] exp_rsp);
    exp_t e;
    ifc.enable    = en;
    ifc.req_valid = v;
    ifc.req_data  = d;
    @(negedge clk);
    chk("req_ready", 32'(ifc.req_ready), 32'(exp_rdy));
    chk("in_flight", 32'(ifc.in_flight), 32'(exp_if));
    chk("idle", 32'(ifc.idle), 32'(exp_idle));
    if (exp_rdy != 4'b0000) begin
      e.vld  = exp_rdy;
      e.data = exp_rsp;
      e.due  = cyc_n + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifc.rsp_valid != 4'b0000) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=%0h expected=0 (cycle %0d)", ifc.rsp_valid, cyc_n);
        end else begin
          e = sb.pop_front();
          chk("rsp_valid", 32'(ifc.rsp_valid), 32'(e.vld));
          chk("rsp_data", ifc.rsp_data, e.data);
          chk("rsp_cycle", cyc_n, e.due);
        end
      end else begin
        chk("rsp_data_idle", ifc.rsp_data, 32'h0);
        if (sb.size() > 0 && sb[0].due <= cyc_n) begin
          e = sb.pop_front();
          checks++;
          failures++;
          $display("FAIL rsp_missing actual=0 expected=%0h (cycle %0d)", e.vld, cyc_n);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] d;
    logic [31:0]  lane;
    rst_n         = 1'b0;
    ifc.enable    = 1'b0;
    ifc.req_valid = '0;
    ifc.req_data  = '0;
    cyc(1'b0, 4'b0000, '0, 4'b0000, 0, 1'b1, 32'h0);
    cyc(1'b0, 4'b0000, '0, 4'b0000, 0, 1'b1, 32'h0);
    rst_n = 1'b1;

    // single op from requester 0
    cyc(1'b1, 4'b0001, 128'h10, 4'b0001, 0, 1'b0, 32'h0000003A);
    cyc(1'b1, 4'b0000, '0, 4'b0000, 1, 1'b0, 32'h0);
    cyc(1'b1, 4'b0000, '0, 4'b0000, 1, 1'b0, 32'h0);
    cyc(1'b1, 4'b0000, '0, 4'b0000, 0, 1'b1, 32'h0);

    // data cases; also brings rr_ptr back to 0
    cyc(1'b1, 4'b0010, {32'h0, 32'h0, 32'h11, 32'h0}, 4'b0010, 0, 1'b0, 32'h0000003B);
    cyc(1'b1, 4'b1000, {32'hFFFFFFFF, 96'h0}, 4'b1000, 1, 1'b0, 32'h00000029);

    // all four requesters every cycle
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 4; r++) begin
        lane = 32'h1000 * k + 32'h11 * r + 32'h1;
        d[r*32 +: 32] = lane;
      end
      lane = d[(k % 4)*32 +: 32];
      cyc(1'b1, 4'b1111, d, 4'(1 << (k % 4)), 2, 1'b0, addmol(lane));
    end

    // drain with enable low
    cyc(1'b0, 4'b1111, d, 4'b0000, 2, 1'b0, 32'h0);
    cyc(1'b0, 4'b1111, d, 4'b0000, 1, 1'b0, 32'h0);
    cyc(1'b0, 4'b1111, d, 4'b0000, 0, 1'b1, 32'h0);

    // reset with two ops in flight
    cyc(1'b1, 4'b1111, {32'h0, 32'h0, 32'h0, 32'h10}, 4'b0001, 0, 1'b0, 32'h0000003A);
    cyc(1'b1, 4'b1111, {32'h0, 32'h0, 32'h20, 32'h0}, 4'b0010, 1, 1'b0, 32'h0000004A);
    rst_n = 1'b0;
    sb.delete();
    cyc(1'b1, 4'b1111, '0, 4'b0000, 0, 1'b1, 32'h0);
    rst_n = 1'b1;
    cyc(1'b0, 4'b0000, '0, 4'b0000, 0, 1'b1, 32'h0);
    cyc(1'b0, 4'b0000, '0, 4'b0000, 0, 1'b1, 32'h0);
    cyc(1'b1, 4'b1111, {32'h0, 32'h0, 32'h0, 32'h11}, 4'b0001, 0, 1'b0, 32'h0000003B);
    cyc(1'b0, 4'b0000, '0, 4'b0000, 1, 1'b0, 32'h0);
    cyc(1'b0, 4'b0000, '0, 4'b0000, 1, 1'b0, 32'h0);
    cyc(1'b0, 4'b0000, '0, 4'b0000, 0, 1'b1, 32'h0);

    // random pipe_out with nothing issued
    rand_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 4'b0000, '0, 4'b0000, 0, 1'b1, 32'h0);
    end

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
